// File: rtl/inst_cache_pkg.sv
// Shared geometry, FSM state codes and constants for the instruction cache.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional feature macro: ICACHE_PERF_EN adds hit/miss counters to inst_cache.
package inst_cache_pkg;

  localparam int INDEX_W = 6;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;
  localparam int LINES   = 1 << INDEX_W;

  localparam logic        True_v   = 1'b1;
  localparam logic        False_v  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_REQ  = 2'd1,
    ICACHE_WAIT = 2'd2
  } icache_state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// Latency: n/a (wiring only). Backpressure: if_busy toward IF, mc_inst_busy from controller.
// slave = the cache itself, master = IF stage plus memory controller.
interface inst_cache_if;
  import inst_cache_pkg::*;

  logic              if_re;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic              if_flush;
  logic [31:0]       if_data;
  logic              if_valid;
  logic              if_busy;
  logic              mc_inst_re;
  logic [ADDR_W-1:0] mc_inst_addr;
  logic [31:0]       mc_inst_data;
  logic              mc_inst_busy;

  modport slave (
    input  if_re, if_addr, if_cancel, if_flush, mc_inst_data, mc_inst_busy,
    output if_data, if_valid, if_busy, mc_inst_re, mc_inst_addr
  );

  modport master (
    output if_re, if_addr, if_cancel, if_flush, mc_inst_data, mc_inst_busy,
    input  if_data, if_valid, if_busy, mc_inst_re, mc_inst_addr
  );

endinterface

// File: rtl/inst_cache_array.sv
// Direct-mapped tag/valid/data storage: one write port, one combinational lookup, bulk valid clear.
// Latency: lookup is combinational; writes and clears land on the next clock edge.
// Backpressure: none; the caller gates we_i/clr_i with the global ready.
module inst_cache_array
  import inst_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic               clr_i,
  input  logic [INDEX_W-1:0] widx_i,
  input  logic [TAG_W-1:0]   wtag_i,
  input  logic [31:0]        wdata_i,
  input  logic [INDEX_W-1:0] ridx_i,
  input  logic [TAG_W-1:0]   rtag_i,
  output logic               hit_o,
  output logic [31:0]        rdata_o
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Valid bits: cleared by reset or flush; clear beats a same-cycle fill.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx_i] <= True_v;
    end
  end

  // Tag and data payload are never reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[widx_i]  <= wtag_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  assign hit_o   = valid_q[ridx_i] && (tag_q[ridx_i] == rtag_i);
  assign rdata_o = data_q[ridx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped one-word-per-line I-cache between IF and the memory controller instruction port.
// Latency: hit 1 cycle; miss 1 + controller arbitration/service + 1 cycles.
// Backpressure: if_busy high during a miss (new requests ignored); waits unbounded on mc_inst_busy; rdy=0 freezes all.
// Optional feature macro: ICACHE_PERF_EN adds perf_hit_cnt / perf_miss_cnt outputs.
module inst_cache
  import inst_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  inst_cache_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  icache_state_e     state_q, state_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              if_busy_q, if_busy_d;
  logic              mc_re_q, mc_re_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic              drop_q, drop_d;      // fetch was cancelled: complete the fill, suppress if_valid
  logic              nofill_q, nofill_d;  // flushed mid-miss: forward the word, do not cache it
  logic              arr_we, arr_clr, arr_hit;
  logic [31:0]       arr_rdata;
  logic              lookup_req;
  logic              unused_addr_bits;

  assign lookup_req       = bus.if_re && !bus.if_cancel;
  assign unused_addr_bits = ^{bus.if_addr[1:0], mc_addr_q[1:0]};

  // The fill always targets the latched miss address, not the live fetch address.
  inst_cache_array u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we && rdy),
    .clr_i   (arr_clr && rdy),
    .widx_i  (mc_addr_q[INDEX_W+1:2]),
    .wtag_i  (mc_addr_q[ADDR_W-1:INDEX_W+2]),
    .wdata_i (bus.mc_inst_data),
    .ridx_i  (bus.if_addr[INDEX_W+1:2]),
    .rtag_i  (bus.if_addr[ADDR_W-1:INDEX_W+2]),
    .hit_o   (arr_hit),
    .rdata_o (arr_rdata)
  );

  // Next-state and output decode for the IDLE/REQ/WAIT miss handler.
  always_comb begin
    state_d    = state_q;
    if_valid_d = False_v;
    if_data_d  = if_data_q;
    if_busy_d  = if_busy_q;
    mc_re_d    = mc_re_q;
    mc_addr_d  = mc_addr_q;
    drop_d     = drop_q;
    nofill_d   = nofill_q;
    arr_we     = False_v;
    arr_clr    = False_v;

    // While a miss is in flight, cancel and flush only mark the transaction.
    if (state_q != ICACHE_IDLE) begin
      if (bus.if_cancel) drop_d = True_v;
      if (bus.if_flush) begin
        arr_clr  = True_v;
        nofill_d = True_v;
      end
    end

    unique case (state_q)
      ICACHE_IDLE: begin
        if (bus.if_flush) begin
          arr_clr = True_v;
        end else if (lookup_req) begin
          if (arr_hit) begin
            if_valid_d = True_v;
            if_data_d  = arr_rdata;
          end else begin
            mc_re_d   = True_v;
            mc_addr_d = {bus.if_addr[ADDR_W-1:2], 2'b00};
            if_busy_d = True_v;
            drop_d    = False_v;
            nofill_d  = False_v;
            state_d   = ICACHE_REQ;
          end
        end
      end
      ICACHE_REQ: begin
        if (bus.mc_inst_busy) begin
          mc_re_d = False_v;
          state_d = ICACHE_WAIT;
        end
      end
      ICACHE_WAIT: begin
        if (!bus.mc_inst_busy) begin
          arr_we     = !nofill_q && !bus.if_flush;
          if_valid_d = !drop_q && !bus.if_cancel;
          if_data_d  = bus.mc_inst_data;
          if_busy_d  = False_v;
          drop_d     = False_v;
          nofill_d   = False_v;
          state_d    = ICACHE_IDLE;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  // Register update: reset has priority and also aborts a miss; otherwise advance only when rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ICACHE_IDLE;
      if_valid_q <= False_v;
      if_data_q  <= ZeroWord;
      if_busy_q  <= False_v;
      mc_re_q    <= False_v;
      mc_addr_q  <= '0;
      drop_q     <= False_v;
      nofill_q   <= False_v;
    end else if (rdy) begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_data_q  <= if_data_d;
      if_busy_q  <= if_busy_d;
      mc_re_q    <= mc_re_d;
      mc_addr_q  <= mc_addr_d;
      drop_q     <= drop_d;
      nofill_q   <= nofill_d;
    end
  end

  // A redirect in the response cycle still kills the word.
  assign bus.if_valid     = if_valid_q && !bus.if_cancel;
  assign bus.if_data      = if_data_q;
  assign bus.if_busy      = if_busy_q;
  assign bus.mc_inst_re   = mc_re_q;
  assign bus.mc_inst_addr = mc_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        idle_lookup;

  assign idle_lookup = (state_q == ICACHE_IDLE) && !bus.if_flush && lookup_req;

  // Free-running hit/miss counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= ZeroWord;
      miss_cnt_q <= ZeroWord;
    end else if (rdy && idle_lookup) begin
      if (arr_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else         miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed cases plus random fetches against a line-table model.
// The memory controller is modelled with programmable arbitration delay and service length.
module tb_inst_cache;

  logic clk;
  logic rst;
  logic rdy;

  inst_cache_if bus ();

  inst_cache dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per line, a valid flag and the cached word address.
  bit          mvalid [64];
  logic [29:0] mtag   [64];
  logic [31:0] mem    [logic [31:0]];

  int arb_delay  = 0;
  int svc_len    = 1;
  bit mc_granted = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  // Memory controller: after arbitration, busy high for svc_len cycles, then data with busy low.
  initial begin : mc_model
    logic [31:0] maddr;
    bus.mc_inst_busy = 1'b0;
    bus.mc_inst_data = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mc_inst_re === 1'b1 && rdy && !rst) begin
        maddr = bus.mc_inst_addr;
        for (int i = 0; i < arb_delay; i++) @(negedge clk);
        bus.mc_inst_busy = 1'b1;
        mc_granted = 1'b1;
        for (int i = 0; i < svc_len; i++) @(negedge clk);
        bus.mc_inst_data = mem_word(maddr);
        bus.mc_inst_busy = 1'b0;
      end
    end
  end

  // mode: 0 plain, 1 cancel in WAIT, 2 flush in WAIT, 3 rdy low for 3 cycles in WAIT
  task automatic fetch(input logic [31:0] a, input int arb, input int svc, input int mode);
    int          idx;
    logic [31:0] w;
    bit          exp_hit;
    bit          done;
    bit          injected;
    int          re_drops;
    idx      = int'(a[7:2]);
    w        = mem_word({a[31:2], 2'b00});
    exp_hit  = mvalid[idx] && (mtag[idx] == a[31:2]);
    arb_delay  = arb;
    svc_len    = svc;
    mc_granted = 1'b0;
    bus.if_re   = 1'b1;
    bus.if_addr = a;
    @(negedge clk); #1;
    if (exp_hit) begin
      chk("hit_valid", 32'(bus.if_valid), 32'd1);
      chk("hit_data", bus.if_data, w);
      chk("hit_no_mc_re", 32'(bus.mc_inst_re), 32'd0);
      bus.if_re = 1'b0;
      @(negedge clk); #1;
      chk("hit_pulse", 32'(bus.if_valid), 32'd0);
    end else begin
      chk("miss_busy", 32'(bus.if_busy), 32'd1);
      chk("miss_re", 32'(bus.mc_inst_re), 32'd1);
      chk("miss_addr", bus.mc_inst_addr, {a[31:2], 2'b00});
      done = 0; injected = 0; re_drops = 0;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clk); #1;
        bus.if_cancel = 1'b0;
        bus.if_flush  = 1'b0;
        if (!mc_granted && !bus.mc_inst_re) re_drops++;
        if (mc_granted && !bus.if_busy) begin
          done = 1;
          chk("fill_valid", 32'(bus.if_valid), (mode == 1) ? 32'd0 : 32'd1);
          if (mode != 1) chk("fill_data", bus.if_data, w);
          chk("fill_re_low", 32'(bus.mc_inst_re), 32'd0);
        end else if (mc_granted && !bus.mc_inst_re && !injected && mode != 0) begin
          injected = 1;
          case (mode)
            1: begin bus.if_cancel = 1'b1; bus.if_re = 1'b0; end
            2: begin bus.if_flush = 1'b1; clear_model(); end
            default: begin
              rdy = 1'b0;
              for (int k = 0; k < 3; k++) begin
                @(negedge clk); #1;
                chk("stall_busy", 32'(bus.if_busy), 32'd1);
                chk("stall_re", 32'(bus.mc_inst_re), 32'd0);
                chk("stall_valid", 32'(bus.if_valid), 32'd0);
                chk("stall_addr", bus.mc_inst_addr, {a[31:2], 2'b00});
              end
              rdy = 1'b1;
            end
          endcase
        end
      end
      chk("miss_completed", 32'(done), 32'd1);
      chk("re_held_until_grant", re_drops, 0);
      bus.if_re = 1'b0;
      @(negedge clk); #1;
      chk("fill_pulse", 32'(bus.if_valid), 32'd0);
      if (!(mode == 2 && injected)) begin
        mvalid[idx] = 1'b1;
        mtag[idx]   = a[31:2];
      end
    end
  endtask

  // Flush in IDLE with a same-cycle request that would otherwise hit.
  task automatic flush_idle(input logic [31:0] a);
    bus.if_flush = 1'b1;
    bus.if_re    = 1'b1;
    bus.if_addr  = a;
    @(negedge clk); #1;
    chk("flush_idle_valid", 32'(bus.if_valid), 32'd0);
    chk("flush_idle_re", 32'(bus.mc_inst_re), 32'd0);
    chk("flush_idle_busy", 32'(bus.if_busy), 32'd0);
    bus.if_flush = 1'b0;
    bus.if_re    = 1'b0;
    clear_model();
  endtask

  // Two hits presented on consecutive cycles.
  task automatic back_to_back(input logic [31:0] a0, input logic [31:0] a1);
    bus.if_re   = 1'b1;
    bus.if_addr = a0;
    @(negedge clk); #1;
    chk("b2b_valid0", 32'(bus.if_valid), 32'd1);
    chk("b2b_data0", bus.if_data, mem_word(a0));
    bus.if_addr = a1;
    @(negedge clk); #1;
    chk("b2b_valid1", 32'(bus.if_valid), 32'd1);
    chk("b2b_data1", bus.if_data, mem_word(a1));
    bus.if_re = 1'b0;
    @(negedge clk); #1;
    chk("b2b_end", 32'(bus.if_valid), 32'd0);
  endtask

  // Cancel together with a request (no lookup), then cancel in a hit response cycle.
  task automatic cancel_cases(input logic [31:0] a);
    bus.if_re     = 1'b1;
    bus.if_addr   = a;
    bus.if_cancel = 1'b1;
    @(negedge clk); #1;
    chk("cancel_req_valid", 32'(bus.if_valid), 32'd0);
    chk("cancel_req_re", 32'(bus.mc_inst_re), 32'd0);
    bus.if_cancel = 1'b0;
    @(negedge clk); #1;
    bus.if_re     = 1'b0;
    bus.if_cancel = 1'b1;
    #1;
    chk("cancel_resp_valid", 32'(bus.if_valid), 32'd0);
    @(negedge clk); #1;
    bus.if_cancel = 1'b0;
    chk("cancel_after_valid", 32'(bus.if_valid), 32'd0);
  endtask

  // Reset while the controller is still arbitrating; its late answer must be ignored.
  task automatic reset_mid_miss(input logic [31:0] a);
    arb_delay  = 6;
    svc_len    = 2;
    mc_granted = 1'b0;
    bus.if_re   = 1'b1;
    bus.if_addr = a;
    repeat (3) begin @(negedge clk); #1; end
    chk("rstmm_re_before", 32'(bus.mc_inst_re), 32'd1);
    rst = 1'b1;
    bus.if_re = 1'b0;
    @(negedge clk); #1;
    chk("rstmm_re", 32'(bus.mc_inst_re), 32'd0);
    chk("rstmm_busy", 32'(bus.if_busy), 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    chk("rstmm_late_busy", 32'(bus.if_busy), 32'd0);
    chk("rstmm_late_valid", 32'(bus.if_valid), 32'd0);
    clear_model();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1;
    rdy = 1'b1;
    bus.if_re     = 1'b0;
    bus.if_addr   = 32'h0;
    bus.if_cancel = 1'b0;
    bus.if_flush  = 1'b0;
    mem[32'h0000_0100] = 32'h0010_0093;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_busy", 32'(bus.if_busy), 32'd0);
    chk("rst_re", 32'(bus.mc_inst_re), 32'd0);
    chk("rst_addr", bus.mc_inst_addr, 32'd0);
    chk("rst_data", bus.if_data, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    fetch(32'h0000_0100, 2, 8, 0);   // cold miss
    fetch(32'h0000_0100, 0, 1, 0);   // hit
    fetch(32'h0000_0200, 1, 3, 0);   // conflict miss, same index
    fetch(32'h0000_0100, 0, 2, 0);   // evicted, misses again
    fetch(32'h0000_0104, 1, 4, 1);   // cancel in WAIT
    fetch(32'h0000_0104, 0, 1, 0);   // still filled -> hit
    flush_idle(32'h0000_0100);
    fetch(32'h0000_0100, 0, 2, 0);   // miss after flush
    fetch(32'h0000_0302, 0, 3, 2);   // flush in WAIT: forwarded, not cached
    fetch(32'h0000_0300, 0, 1, 0);   // misses again
    fetch(32'h0000_0400, 20, 8, 0);  // long arbitration
    fetch(32'h0000_0109, 1, 6, 3);   // rdy stall in WAIT
    back_to_back(32'h0000_0400, 32'h0000_0108);
    cancel_cases(32'h0000_0400);
    reset_mid_miss(32'h0000_010C);
    fetch(32'h0000_0400, 0, 2, 0);   // miss after reset

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          r;
      int          mode;
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      mode = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
      if (mode == 4) flush_idle(a);
      else fetch(a, int'($urandom_range(0, 5)), int'($urandom_range(1, 8)), mode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
